// File: rtl/latch_load_pkg.sv
// Shared types, timing defaults and width helpers for the latch bank loader.
package latch_load_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    SETUP  = 3'd2,
    ENABLE = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_EN_CYC    = 2;
  localparam int DEF_HOLD_CYC  = 1;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/latch_load_ctrl_cyc_timer.sv
// Loadable down-counter with a zero flag; times the SETUP/ENABLE/HOLD windows.
module cyc_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (cnt_q != '0)   cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/latch_load_ctrl.sv
// Serial-to-parallel loader driving a gated D-latch bank with framed setup/enable/hold.
// Optional even-parity check on each word is enabled by defining LATCH_LOAD_PARITY_EN.
// Handshake: a bit transfers on a rising edge where s_valid && s_ready; s_ready depends on state only.
module latch_load_ctrl
  import latch_load_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int EN_CYC    = DEF_EN_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_en,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
`ifdef LATCH_LOAD_PARITY_EN
  ,
  output logic             err
`endif
);

  localparam int BW = cnt_width(WIDTH);
  localparam int TW = cnt_width(max3(SETUP_CYC, EN_CYC, HOLD_CYC));
`ifdef LATCH_LOAD_PARITY_EN
  localparam int LAST_IDX = WIDTH;
`else
  localparam int LAST_IDX = WIDTH - 1;
`endif

  state_t           state_q, state_d;
  logic [BW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] lat_d_q, lat_d_d;
  logic             lat_en_q, lat_en_d;
  logic             done_q, done_d;
  logic             tmr_load, tmr_zero;
  logic [TW-1:0]    tmr_val;
  logic             accept, last_bit;

  assign accept   = s_valid && s_ready;
  assign last_bit = (cnt_q == BW'(LAST_IDX));

  cyc_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Timer is loaded with window-1 on entry so the zero flag marks the window's last cycle.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE:   if (accept) state_d = SHIFT;
      SHIFT: begin
        if (accept && last_bit) begin
`ifdef LATCH_LOAD_PARITY_EN
          if (s_data == ^shift_q) begin
            state_d  = SETUP;
            tmr_load = 1'b1;
            tmr_val  = TW'(SETUP_CYC - 1);
          end else begin
            state_d  = IDLE;
          end
`else
          state_d  = SETUP;
          tmr_load = 1'b1;
          tmr_val  = TW'(SETUP_CYC - 1);
`endif
        end
      end
      SETUP: if (tmr_zero) begin
        state_d  = ENABLE;
        tmr_load = 1'b1;
        tmr_val  = TW'(EN_CYC - 1);
      end
      ENABLE: if (tmr_zero) begin
        state_d  = HOLD;
        tmr_load = 1'b1;
        tmr_val  = TW'(HOLD_CYC - 1);
      end
      HOLD:    if (tmr_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    lat_d_d  = lat_d_q;
    lat_en_d = (state_d == ENABLE);
    done_d   = (state_q == HOLD) && (state_d == IDLE);
    if (accept) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (cnt_q == BW'(i)) shift_d[i] = s_data;
      end
      cnt_d = cnt_q + BW'(1);
    end
    if (state_q == SHIFT && state_d == SETUP) lat_d_d = shift_d;
    if (state_d == IDLE) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shift_q  <= '0;
      lat_d_q  <= '0;
      lat_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      lat_d_q  <= lat_d_d;
      lat_en_q <= lat_en_d;
      done_q   <= done_d;
    end
  end

`ifdef LATCH_LOAD_PARITY_EN
  logic err_q, err_d;
  assign err_d = (state_q == SHIFT) && (state_d == IDLE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`endif

  always_comb begin
    s_ready   = (state_q == IDLE) || (state_q == SHIFT);
    busy      = (state_q != IDLE);
    dbg_state = state_q;
  end

  assign lat_d  = lat_d_q;
  assign lat_en = lat_en_q;
  assign done   = done_q;

endmodule

// File: tb/tb_latch_load_ctrl.sv
// Bench for latch_load_ctrl: timeline-based reference model plus directed literal checks.
module tb_latch_load_ctrl;
  import latch_load_pkg::*;

  localparam int W = 8;
  localparam int S = 1;
  localparam int E = 2;
  localparam int H = 1;
`ifdef LATCH_LOAD_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid;
  logic         s_data;
  logic         s_ready;
  logic [W-1:0] lat_d;
  logic         lat_en;
  logic         busy;
  logic         done;
  state_t       dbg_state;
`ifdef LATCH_LOAD_PARITY_EN
  logic         err;
`endif

  latch_load_ctrl #(.WIDTH(W), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .lat_d     (lat_d),
    .lat_en    (lat_en),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
`ifdef LATCH_LOAD_PARITY_EN
    ,
    .err       (err)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard and model state
  int           n_chk = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           load_n = -1000;
  int           err_n = -1000;
  logic         in_win;
  logic [W-1:0] exp_lat_d;
  logic [W-1:0] exp_q[$];
  logic         bits_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    bits_q.delete();
    exp_q.delete();
    load_n    = -1000;
    err_n     = -1000;
    exp_lat_d = '0;
  endtask

  task automatic model_complete();
    logic [W-1:0] wd;
    for (int i = 0; i < W; i++) wd[i] = bits_q[i];
`ifdef LATCH_LOAD_PARITY_EN
    if ((($countones(wd) + int'(bits_q[W])) % 2) == 0) begin
      load_n = cyc;
      exp_q.push_back(wd);
    end else begin
      err_n = cyc;
    end
`else
    load_n = cyc;
    exp_q.push_back(wd);
`endif
    bits_q.delete();
  endtask

  // One cycle: compare outputs against the model, then drive inputs for this cycle.
  task automatic step(input logic v, input logic d);
    int rel;
    @(negedge clk);
    cyc++;
    rel    = cyc - load_n;
    in_win = (rel >= 1) && (rel <= S + E + H);
    if (rel == 1 && exp_q.size() > 0) exp_lat_d = exp_q.pop_front();
    chk("s_ready", 32'(s_ready), 32'(!in_win));
    chk("busy",    32'(busy),    32'(in_win || bits_q.size() > 0));
    chk("lat_en",  32'(lat_en),  32'((rel >= S + 1) && (rel <= S + E)));
    chk("done",    32'(done),    32'(rel == S + E + H + 1));
    chk("lat_d",   32'(lat_d),   32'(exp_lat_d));
`ifdef LATCH_LOAD_PARITY_EN
    chk("err",     32'(err),     32'(cyc == err_n + 1));
`endif
    s_valid = v;
    s_data  = d;
    if (v && !in_win) begin
      bits_q.push_back(d);
      if (bits_q.size() == NB) model_complete();
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic bad_par);
    for (int i = 0; i < W; i++) step(1'b1, w[i]);
`ifdef LATCH_LOAD_PARITY_EN
    step(1'b1, (^w) ^ bad_par);
`else
    if (bad_par) $display("note: parity bit ignored in this build");
`endif
  endtask

  task automatic async_reset_checks(input string tag);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    #1;
    chk({tag, "_lat_d"},   32'(lat_d),   32'h0);
    chk({tag, "_lat_en"},  32'(lat_en),  32'h0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'h1);
    chk({tag, "_busy"},    32'(busy),    32'h0);
    chk({tag, "_done"},    32'(done),    32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] gw;
    int idx;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    step(1'b0, 1'b0);
    chk("rst_lat_d", 32'(lat_d), 32'h0);
    chk("rst_ready", 32'(s_ready), 32'h1);

    // basic load of 0xA5, last bit in cycle N
    send_word(8'hA5, 1'b0);
    step(1'b0, 1'b0);
    chk("basic_lat_d_n1", 32'(lat_d), 32'hA5);
    chk("basic_en_n1", 32'(lat_en), 32'h0);
    step(1'b0, 1'b0);
    chk("basic_en_n2", 32'(lat_en), 32'h1);
    step(1'b0, 1'b0);
    chk("basic_en_n3", 32'(lat_en), 32'h1);
    step(1'b0, 1'b0);
    chk("basic_en_n4", 32'(lat_en), 32'h0);
    step(1'b0, 1'b0);
    chk("basic_done_n5", 32'(done), 32'h1);
    chk("basic_ready_n5", 32'(s_ready), 32'h1);

    // gapped input of 0xA5, then bits offered during the busy window
    gw  = 8'hA5;
    idx = 0;
    while (idx < NB) begin
      logic v;
      logic d;
      v = 1'($urandom_range(0, 1));
      d = (idx < W) ? gw[idx] : ^gw;
      step(v, d);
      if (v) idx++;
    end
    repeat (S + E + H) step(1'b1, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0);
    chk("gap_done", 32'(done), 32'h1);
    chk("gap_lat_d", 32'(lat_d), 32'hA5);
    chk("gap_busy", 32'(busy), 32'h0);

    // back-to-back: second word starts in the done cycle
    send_word(8'h3C, 1'b0);
    repeat (S + E + H) step(1'b0, 1'b0);
    send_word(8'hC3, 1'b0);
    chk("b2b_lat_d_hold", 32'(lat_d), 32'h3C);
    step(1'b0, 1'b0);
    chk("b2b_lat_d_new", 32'(lat_d), 32'hC3);
    repeat (S + E + H + 1) step(1'b0, 1'b0);

    // randomized traffic
    repeat (400) step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));

    // reset mid-sequence with a partial word
    repeat (3) step(1'b1, 1'b1);
    async_reset_checks("rst_mid");
    repeat (2) step(1'b0, 1'b0);

    // reset during ENABLE: lat_en drops immediately, no done follows
    send_word(8'h5A, 1'b0);
    repeat (S + 1) step(1'b0, 1'b0);
    chk("en_before_rst", 32'(lat_en), 32'h1);
    async_reset_checks("rst_en");
    repeat (8) step(1'b0, 1'b0);

`ifdef LATCH_LOAD_PARITY_EN
    // good parity load, then 0xA5 with wrong parity bit 1
    send_word(8'h5A, 1'b0);
    repeat (S + E + H + 1) step(1'b0, 1'b0);
    chk("par_good_lat_d", 32'(lat_d), 32'h5A);
    send_word(8'hA5, 1'b1);
    step(1'b0, 1'b0);
    chk("par_err_pulse", 32'(err), 32'h1);
    chk("par_lat_d_kept", 32'(lat_d), 32'h5A);
    repeat (6) step(1'b0, 1'b0);
    chk("par_err_gone", 32'(err), 32'h0);
    send_word(8'hA5, 1'b0);
    repeat (S + E + H + 1) step(1'b0, 1'b0);
    chk("par_ok_lat_d", 32'(lat_d), 32'hA5);
`endif

    repeat (4) step(1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
